oport_uart_tx: RTL



---
 rtl/oport_uart_tx_if.sv | 23 ++
 rtl/oport_uart_tx.sv | 135 +++++++++++++
 2 files changed

// File: rtl/oport_uart_tx_if.sv
// Output-port write strobe/data from the CPU plus UART transmitter line and FIFO status.
interface oport_uart_tx_if #(
  parameter int DEPTH_LOG2 = 2
);
  logic                wr_en;
  logic [7:0]          wr_data;
  logic                tx;
  logic                busy;
  logic                empty;
  logic                full;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;

  modport master (
    output wr_en, wr_data,
    input  tx, busy, empty, full, level, overflow
  );

  modport slave (
    input  wr_en, wr_data,
    output tx, busy, empty, full, level, overflow
  );
endinterface

// File: rtl/oport_uart_tx.sv
// Buffers CPU output-port bytes in a small FIFO and sends them as UART 8N1.
// state | meaning
// IDLE  | line high, pops the next byte as soon as the FIFO is non-empty
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high) for one bit period
module oport_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH_LOG2   = 2
) (
  input  logic            clk,
  input  logic            reset,
  oport_uart_tx_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      baud_cnt, baud_cnt_nxt;
  logic [2:0]            bit_idx, bit_idx_nxt;
  logic [7:0]            shift, shift_nxt;
  logic                  tx_q, tx_nxt;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;
  logic                  fifo_empty, fifo_full, pop, push, baud_wrap;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == (DEPTH_LOG2+1)'(DEPTH));
  assign pop        = (state == IDLE) && !fifo_empty;
  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign push       = bus.wr_en && (!fifo_full || pop);
  assign baud_wrap  = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (bus.wr_en && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
      tx_q     <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt + 1'b1;
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift;
    case (state)
      IDLE: begin
        baud_cnt_nxt = '0;
        bit_idx_nxt  = '0;
        if (pop) begin
          state_nxt = START;
          shift_nxt = mem[rd_ptr];
        end
      end
      START: begin
        if (baud_wrap) begin
          state_nxt    = DATA;
          baud_cnt_nxt = '0;
          bit_idx_nxt  = '0;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            shift_nxt   = shift >> 1;
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_wrap) begin
          state_nxt    = IDLE;
          baud_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line level is computed for the upcoming state so the flop holds it for the whole bit.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = (state != IDLE);
  assign bus.empty    = fifo_empty;
  assign bus.full     = fifo_full;
  assign bus.level    = level;
  assign bus.overflow = overflow;
endmodule
